// File: rtl/trng_ctrl.sv
// trng_ctrl: sequencing and bus-interface controller for the ring-oscillator TRNG.
// Holds the source in reset until enabled, discards a warm-up burst, runs a
// repetition-count health test on every sample and buffers passing samples in a
// small FIFO that the PicoRV32 reads over its native memory interface.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rng_data/valid  - 32-bit sample and one-cycle qualifying strobe from the source
//   rng_rst         - reset to the source (high while IDLE or FAULT)
//   mem_*           - PicoRV32 native memory interface (one-cycle registered ack)
//
// Register map (offset from BASE_ADDR):
//   0x0 CTRL   bit0 enable (R/W); any write clears overflow
//   0x4 STATUS bit0 avail, bit1 fault, bit2 overflow, bit3 running, [11:8] count
//   0x8 DATA   read pops the FIFO head; empty FIFO reads 0 without popping
//   0xC        reads 0
module trng_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h0300_0000,
    parameter int          WARMUP_WORDS = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          REP_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rng_data,
    input  logic        rng_valid,
    output logic        rng_rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAULT} state_t;

    typedef struct packed {
        logic       acc;   // accepted this cycle
        logic       wr;    // any strobe set
        logic [1:0] off;   // word offset in the register block
    } bus_req_t;

    state_t   state, state_nxt;
    bus_req_t req;

    logic          enable;
    logic          overflow;
    logic [3:0]    rep;
    logic [31:0]   last;
    logic [7:0]    wcnt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] wp, rp;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic          ctrl_wr, en_wr, dis, en_rise, data_rd;
    logic          tested, trip, warm_done, push, push_ok, pop, full, flush;
    logic [3:0]    rep_nxt;
    logic [31:0]   status, rd_val;
    logic          unused_bits;

    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:1]};

    // Only one access per ack cycle: a still-high mem_valid during the
    // ack cycle is not re-accepted.
    always_comb begin
        req.acc = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !mem_ready;
        req.wr  = |mem_wstrb;
        req.off = mem_addr[3:2];
    end

    assign ctrl_wr = req.acc && req.wr && (req.off == 2'd0);
    assign en_wr   = ctrl_wr && mem_wstrb[0];
    assign dis     = en_wr && !mem_wdata[0];
    assign en_rise = en_wr && mem_wdata[0] && !enable;
    assign data_rd = req.acc && !req.wr && (req.off == 2'd2);

    // A disable in the same cycle as a sample drops the sample.
    assign tested    = rng_valid && !dis && (state == S_WARMUP || state == S_RUN);
    assign rep_nxt   = (rep == 4'd0 || rng_data != last) ? 4'd1 : rep + 4'd1;
    assign trip      = tested && (rep_nxt == 4'(REP_LIMIT));
    assign warm_done = (state == S_WARMUP) && tested && !trip &&
                       (wcnt + 8'd1 == 8'(WARMUP_WORDS));

    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign pop     = data_rd && (cnt != '0);
    assign push    = (state == S_RUN) && tested && !trip;
    assign push_ok = push && (!full || pop);
    // The pop still returns the head word (rd_val samples the pre-flush FIFO).
    assign flush   = dis || trip;

    always_comb begin
        status        = '0;
        status[0]     = (cnt != '0);
        status[1]     = (state == S_FAULT);
        status[2]     = overflow;
        status[3]     = (state == S_RUN);
        status[11:8]  = 4'(cnt);
    end

    always_comb begin
        rd_val = '0;
        case (req.off)
            2'd0: rd_val = {31'd0, enable};
            2'd1: rd_val = status;
            2'd2: rd_val = (cnt != '0) ? fifo_mem[rp] : 32'd0;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rng_rst   = (state == S_IDLE) || (state == S_FAULT);
        if (dis) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (en_rise) state_nxt = S_WARMUP;
                S_WARMUP: if (trip) state_nxt = S_FAULT;
                          else if (warm_done) state_nxt = S_RUN;
                S_RUN:    if (trip) state_nxt = S_FAULT;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wp] <= rng_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            enable    <= 1'b0;
            overflow  <= 1'b0;
            rep       <= '0;
            last      <= '0;
            wcnt      <= '0;
            cnt       <= '0;
            wp        <= '0;
            rp        <= '0;
        end else begin
            mem_ready <= req.acc;
            mem_rdata <= (req.acc && !req.wr) ? rd_val : 32'd0;

            if (en_wr) enable <= mem_wdata[0];

            if (push && full && !pop) overflow <= 1'b1;
            else if (ctrl_wr)         overflow <= 1'b0;

            // Health history restarts on disable and on entry to warm-up.
            if (dis || en_rise) begin
                rep  <= '0;
                last <= '0;
                wcnt <= '0;
            end else if (tested) begin
                rep  <= rep_nxt;
                last <= rng_data;
                if (state == S_WARMUP) wcnt <= wcnt + 8'd1;
            end

            if (flush) begin
                cnt <= '0;
                wp  <= '0;
                rp  <= '0;
            end else begin
                if (push_ok) wp <= wp + AW'(1);
                if (pop)     rp <= rp + AW'(1);
                case ({push_ok, pop})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trng_ctrl.sv
// Randomized bench for trng_ctrl against a queue-based behavioural model.
module tb_trng_ctrl;
    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam int          WARM  = 16;
    localparam int          DEPTH = 4;
    localparam int          LIMIT = 4;
    localparam int M_IDLE = 0, M_WARM = 1, M_RUN = 2, M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rng_data = '0;
    logic        rng_valid = 1'b0;
    logic        rng_rst;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    trng_ctrl #(.BASE_ADDR(BASE), .WARMUP_WORDS(WARM), .FIFO_DEPTH(DEPTH),
                .REP_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .rng_data(rng_data), .rng_valid(rng_valid),
        .rng_rst(rng_rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model: the FIFO is a queue, health test is a run length.
    int          m_mode = M_IDLE;
    logic [31:0] q[$];
    bit          m_ovf = 0, m_en = 0, m_ready = 0;
    logic [31:0] m_last = '0, m_rdata = '0;
    int          m_rep = 0, m_wcnt = 0;
    bit          rst_req = 1;

    task automatic model_step(input bit mv, input logic [31:0] addr, input logic [3:0] ws,
                              input logic [31:0] wd, input bit rv, input logic [31:0] d);
        bit acc, is_wr, ctrl, dis, set_ovf;
        int pre, sz;
        logic [1:0] off;
        logic [31:0] val;
        if (rst_req) begin
            m_mode = M_IDLE; q.delete(); m_ovf = 0; m_en = 0; m_ready = 0;
            m_rdata = '0; m_last = '0; m_rep = 0; m_wcnt = 0;
            return;
        end
        acc   = mv && (addr[31:4] == BASE[31:4]) && !m_ready;
        is_wr = (ws != 4'd0);
        off   = addr[3:2];
        pre   = m_mode;
        sz    = q.size();
        case (off)
            2'd0: val = {31'd0, m_en};
            2'd1: val = {20'd0, 4'(sz), 4'd0, pre == M_RUN, m_ovf, pre == M_FAULT, sz != 0};
            2'd2: val = (sz != 0) ? q[0] : 32'd0;
            default: val = '0;
        endcase
        ctrl = acc && is_wr && off == 2'd0;
        if (acc && !is_wr && off == 2'd2 && sz != 0) void'(q.pop_front());
        dis = ctrl && ws[0] && !wd[0];
        set_ovf = 0;
        if (dis) begin
            m_mode = M_IDLE; q.delete(); m_en = 0; m_rep = 0; m_last = '0; m_wcnt = 0;
        end else begin
            if (ctrl && ws[0] && wd[0] && !m_en) begin
                m_en = 1; m_mode = M_WARM; m_rep = 0; m_last = '0; m_wcnt = 0;
            end
            if (rv && (pre == M_WARM || pre == M_RUN)) begin
                m_rep  = (m_rep == 0 || d != m_last) ? 1 : m_rep + 1;
                m_last = d;
                if (m_rep == LIMIT) begin
                    m_mode = M_FAULT; q.delete();
                end else if (pre == M_WARM) begin
                    m_wcnt++;
                    if (m_wcnt == WARM) m_mode = M_RUN;
                end else if (q.size() < DEPTH) q.push_back(d);
                else set_ovf = 1;
            end
        end
        if (ctrl) m_ovf = 0;
        if (set_ovf) m_ovf = 1;
        m_ready = acc;
        m_rdata = (acc && !is_wr) ? val : 32'd0;
    endtask

    task automatic tick(input bit mv, input logic [31:0] addr, input logic [3:0] ws,
                        input logic [31:0] wd, input bit rv, input logic [31:0] d);
        @(negedge clk);
        rst = rst_req; mem_valid = mv; mem_addr = addr; mem_wstrb = ws;
        mem_wdata = wd; rng_valid = rv; rng_data = d;
        model_step(mv, addr, ws, wd, rv, d);
        @(posedge clk);
        #1;
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_ready});
        chk("mem_rdata", mem_rdata, m_rdata);
        chk("rng_rst", {31'd0, rng_rst}, {31'd0, (m_mode == M_IDLE || m_mode == M_FAULT)});
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, '0, '0, '0, 0, '0);
    endtask

    // Second cycle keeps mem_valid high: it must not be re-accepted.
    task automatic wr(input logic [3:0] off, input logic [31:0] v);
        tick(1, BASE + 32'(off), 4'hF, v, 0, '0);
        tick(1, BASE + 32'(off), 4'hF, v, 0, '0);
    endtask

    task automatic rd(input logic [3:0] off);
        tick(1, BASE + 32'(off), '0, '0, 0, '0);
        tick(1, BASE + 32'(off), '0, '0, 0, '0);
    endtask

    task automatic rng(input logic [31:0] d);
        tick(0, '0, '0, '0, 1, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        rst_req = 1; idle(2); rst_req = 0;
        rd(4'h4); rd(4'h0);

        // enable, warm-up, first sample
        wr(4'h0, 32'd1);
        for (int i = 0; i < WARM; i++) rng(32'h1000_0000 + 32'(i));
        rd(4'h4);
        rng(32'hA5A5_0001);
        rd(4'h4); rd(4'h8); rd(4'h4);

        // overflow with five words, CTRL write clears it and keeps data
        for (int i = 0; i < 5; i++) rng(32'h2000_0000 + 32'(i));
        rd(4'h4);
        wr(4'h0, 32'd1);
        rd(4'h4);
        for (int i = 0; i < 4; i++) rd(4'h8);

        // repetition fault
        for (int i = 0; i < 4; i++) rng(32'hDEAD_BEEF);
        rd(4'h4);
        wr(4'h0, 32'd1); rd(4'h4);
        rng(32'h1234_5678); rd(4'h4);
        wr(4'h0, 32'd0); wr(4'h0, 32'd1); rd(4'h4);
        for (int i = 0; i < WARM; i++) rng(32'h3000_0000 + 32'(i));

        // full FIFO, pop and push in the same cycle
        for (int i = 0; i < 4; i++) rng(32'h4000_0000 + 32'(i));
        tick(1, BASE + 32'h8, '0, '0, 1, 32'h4000_00FF);
        tick(1, BASE + 32'h8, '0, '0, 0, '0);
        rd(4'h4);
        for (int i = 0; i < 5; i++) rd(4'h8);

        // unmatched address
        repeat (3) tick(1, BASE + 32'h10, '0, '0, 0, '0);

        // reset during a pending transaction with three words buffered
        for (int i = 0; i < 3; i++) rng(32'h5000_0000 + 32'(i));
        rd(4'h4);
        rst_req = 1; tick(1, BASE + 32'h4, '0, '0, 0, '0);
        rst_req = 0; idle(1);
        rd(4'h4);

        // randomized traffic, re-enabled every round
        for (int r = 0; r < 10; r++) begin
            wr(4'h0, 32'd0); wr(4'h0, 32'd1);
            for (int i = 0; i < 250; i++) begin
                bit          mv, rv;
                int          o;
                logic [3:0]  ws;
                logic [31:0] wd, d;
                mv = ($urandom_range(0, 2) == 0);
                o  = $urandom_range(0, 4);
                ws = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                wd = $urandom;
                wd[0] = ($urandom_range(0, 3) != 0);
                rv = ($urandom_range(0, 2) == 0);
                d  = $urandom_range(0, 1) ? 32'h5A5A_5A5A : 32'($urandom);
                tick(mv, BASE + 32'(o * 4), ws, wd, rv, d);
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
